// File: rtl/fas_pkg.sv
// Shared constants, state codes and helpers for the FAS peak-detect stage.
package fas_pkg;

    localparam int NPT_DEF = 16;
    localparam int DW_DEF  = 16;
    localparam int MAGW    = 2 * DW_DEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SCAN  = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    function automatic int idx_width(input int npt);
        return (npt > 1) ? $clog2(npt) : 1;
    endfunction

endpackage

// File: rtl/fas_peak_detect_if.sv
// Frame handshake between the FFT core (master) and the peak detector (slave).
import fas_pkg::*;

interface fas_peak_detect_if #(
    parameter int NPT = NPT_DEF,
    parameter int DW  = DW_DEF
);
    logic                  fft_valid;
    logic [NPT*2*DW-1:0]   fft_d;
    logic [2*DW-1:0]       threshold;
    logic                  fft_ready;

    modport master (output fft_valid, fft_d, threshold, input fft_ready);
    modport slave  (input fft_valid, fft_d, threshold, output fft_ready);
endinterface

// File: rtl/fas_mag_sq.sv
// Registered squared magnitude re*re + im*im of one signed complex bin.
import fas_pkg::*;

module fas_mag_sq #(
    parameter int DW = DW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] re,
    input  logic signed [DW-1:0] im,
    output logic [2*DW-1:0]      mag
);
    logic signed [2*DW-1:0] re_x;
    logic signed [2*DW-1:0] im_x;
    logic [2*DW-1:0]        re_sq;
    logic [2*DW-1:0]        im_sq;

    assign re_x  = (2*DW)'(re);
    assign im_x  = (2*DW)'(im);
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;

    // Worst case (-2^(DW-1))^2 * 2 = 2^(2DW-1) still fits unsigned.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) mag <= '0;
        else      mag <= re_sq + im_sq;
    end
endmodule

// File: rtl/fas_peak_detect.sv
// Captures one FFT frame, scans its bins serially through the squarer and
// reports the strongest bin, its squared magnitude and threshold/overflow status.
//   state    | meaning
//   IDLE     | ready for a frame
//   SCAN     | bins fed one per cycle into the squarer pipeline
//   FLUSH    | last squared magnitude compared
//   DONE     | results published, done pulse, may accept the next frame
import fas_pkg::*;

module fas_peak_detect #(
    parameter int NPT     = NPT_DEF,
    parameter int DW      = DW_DEF,
    parameter int IDXW    = idx_width(NPT),
    parameter int SKIP_DC = 0
) (
    input  logic              clk,
    input  logic              rst,
    fas_peak_detect_if.slave  fft,
    input  logic              clr_ovf,
    output logic              done,
    output logic [IDXW-1:0]   freq,
    output logic [2*DW-1:0]   peak_mag,
    output logic              no_peak,
    output logic              overflow
);
    localparam int            BW       = 2 * DW;
    localparam int            MW       = 2 * DW;
    localparam bit            SKIP     = (SKIP_DC != 0);
    localparam logic [IDXW:0] K_LAST   = (IDXW+1)'(NPT);
    localparam logic [IDXW-1:0] IDX_INIT = SKIP ? IDXW'(1) : IDXW'(0);

    state_t                state;
    logic [IDXW:0]         k;
    logic [NPT*BW-1:0]     frame_q;
    logic [MW-1:0]         thr_q;
    logic [BW-1:0]         bin_word;
    logic signed [DW-1:0]  bin_re;
    logic signed [DW-1:0]  bin_im;
    logic                  bin_vld;
    logic [IDXW-1:0]       bin_idx;
    logic [MW-1:0]         mag;
    logic                  mag_vld;
    logic [IDXW-1:0]       mag_idx;
    logic [MW-1:0]         max_mag;
    logic [IDXW-1:0]       max_idx;
    logic [MW-1:0]         cand_mag;
    logic [IDXW-1:0]       cand_idx;
    logic                  accept;
    logic                  upd;

    assign fft.fft_ready = (state == ST_IDLE) || (state == ST_DONE);
    assign accept        = fft.fft_valid && fft.fft_ready;
    assign done          = (state == ST_DONE);
    assign bin_word      = frame_q[k[IDXW-1:0]*BW +: BW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        state <= ST_SCAN;
                        k     <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                // k runs one past the last bin so bin NPT-1 reaches the squarer
                ST_SCAN: begin
                    if (k == K_LAST) state <= ST_FLUSH;
                    else             k     <= k + 1'b1;
                end
                ST_FLUSH: state <= ST_DONE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (accept) frame_q <= fft.fft_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_vld <= 1'b0;
            bin_idx <= '0;
            bin_re  <= '0;
            bin_im  <= '0;
            mag_vld <= 1'b0;
            mag_idx <= '0;
        end else begin
            bin_vld <= (state == ST_SCAN) && (k != K_LAST);
            bin_idx <= k[IDXW-1:0];
            bin_re  <= bin_word[BW-1:DW];
            bin_im  <= bin_word[DW-1:0];
            mag_vld <= bin_vld;
            mag_idx <= bin_idx;
        end
    end

    fas_mag_sq #(.DW(DW)) u_mag_sq (
        .clk (clk),
        .rst (rst),
        .re  (bin_re),
        .im  (bin_im),
        .mag (mag)
    );

    // Strictly-greater update keeps the lowest index on ties.
    assign upd      = mag_vld && (mag > max_mag) && !(SKIP && (mag_idx == '0));
    assign cand_mag = upd ? mag     : max_mag;
    assign cand_idx = upd ? mag_idx : max_idx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_mag <= '0;
            max_idx <= '0;
            thr_q   <= '0;
        end else if (accept) begin
            max_mag <= '0;
            max_idx <= IDX_INIT;
            thr_q   <= fft.threshold;
        end else begin
            max_mag <= cand_mag;
            max_idx <= cand_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            freq     <= '0;
            peak_mag <= '0;
            no_peak  <= 1'b0;
        end else if (state == ST_FLUSH) begin
            freq     <= cand_idx;
            peak_mag <= cand_mag;
            no_peak  <= (cand_mag < thr_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                overflow <= 1'b0;
        else if (fft.fft_valid && !fft.fft_ready) overflow <= 1'b1;
        else if (clr_ovf)                        overflow <= 1'b0;
    end
endmodule

// File: tb/tb_fas_peak_detect.sv
// Directed bench for fas_peak_detect: two instances (SKIP_DC 0 and 1) share stimulus
// and are checked every cycle against a frame-level timing/argmax model.
import fas_pkg::*;

module tb_fas_peak_detect;
    localparam int NPT  = 16;
    localparam int DW   = 16;
    localparam int IDXW = 4;
    localparam int BW   = 32;
    localparam int FW   = NPT * BW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fft_valid = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [FW-1:0] fft_d = '0;
    logic [BW-1:0] threshold = '0;

    logic            done0, done1, np0, np1, ovf0, ovf1;
    logic [IDXW-1:0] freq0, freq1;
    logic [BW-1:0]   mag0, mag1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    fas_peak_detect_if #(.NPT(NPT), .DW(DW)) if0 ();
    fas_peak_detect_if #(.NPT(NPT), .DW(DW)) if1 ();

    assign if0.fft_valid = fft_valid;
    assign if0.fft_d     = fft_d;
    assign if0.threshold = threshold;
    assign if1.fft_valid = fft_valid;
    assign if1.fft_d     = fft_d;
    assign if1.threshold = threshold;

    fas_peak_detect #(.NPT(NPT), .DW(DW), .SKIP_DC(0)) dut0 (
        .clk(clk), .rst(rst), .fft(if0), .clr_ovf(clr_ovf), .done(done0),
        .freq(freq0), .peak_mag(mag0), .no_peak(np0), .overflow(ovf0));
    fas_peak_detect #(.NPT(NPT), .DW(DW), .SKIP_DC(1)) dut1 (
        .clk(clk), .rst(rst), .fft(if1), .clr_ovf(clr_ovf), .done(done1),
        .freq(freq1), .peak_mag(mag1), .no_peak(np1), .overflow(ovf1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: argmax over plain integer magnitudes.
    function automatic void calc(input logic [FW-1:0] f, input bit skip, input logic [BW-1:0] thr,
                                 output logic [IDXW-1:0] idx, output logic [BW-1:0] mag,
                                 output bit np);
        longint best = 0;
        int     bi   = skip ? 1 : 0;
        for (int b = 0; b < NPT; b++) begin
            longint re = longint'($signed(f[b*BW+DW +: DW]));
            longint im = longint'($signed(f[b*BW +: DW]));
            longint m  = re*re + im*im;
            if (!(skip && b == 0) && m > best) begin
                best = m;
                bi   = b;
            end
        end
        idx = IDXW'(bi);
        mag = best[BW-1:0];
        np  = (best < longint'(thr));
    endfunction

    int              cyc = 0;
    int              done_at = -1;
    bit              e_ready = 1, e_done = 0, e_ovf = 0;
    logic [IDXW-1:0] e_freq [2];
    logic [BW-1:0]   e_mag  [2];
    bit              e_np   [2];
    logic [IDXW-1:0] p_freq [2];
    logic [BW-1:0]   p_mag  [2];
    bit              p_np   [2];

    always @(posedge clk or negedge rst) begin : model
        bit acc;
        if (!rst) begin
            done_at = -1;
            e_ready = 1; e_done = 0; e_ovf = 0;
            for (int d = 0; d < 2; d++) begin
                e_freq[d] = '0; e_mag[d] = '0; e_np[d] = 0;
            end
        end else begin
            cyc++;
            acc = fft_valid && e_ready;
            if (fft_valid && !e_ready) e_ovf = 1;
            else if (clr_ovf)          e_ovf = 0;
            e_done = (cyc == done_at);
            if (e_done) begin
                for (int d = 0; d < 2; d++) begin
                    e_freq[d] = p_freq[d]; e_mag[d] = p_mag[d]; e_np[d] = p_np[d];
                end
            end
            if (acc) begin
                for (int d = 0; d < 2; d++) calc(fft_d, d == 1, threshold, p_freq[d], p_mag[d], p_np[d]);
                done_at = cyc + NPT + 2;
            end
            e_ready = !(done_at > cyc);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready0", if0.fft_ready, e_ready);
            chk("ready1", if1.fft_ready, e_ready);
            chk("done0", done0, e_done);
            chk("done1", done1, e_done);
            chk("ovf0", ovf0, e_ovf);
            chk("ovf1", ovf1, e_ovf);
            chk("freq0", freq0, e_freq[0]);
            chk("freq1", freq1, e_freq[1]);
            chk("mag0", mag0, e_mag[0]);
            chk("mag1", mag1, e_mag[1]);
            chk("np0", np0, e_np[0]);
            chk("np1", np1, e_np[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [FW-1:0] fill(input logic [15:0] re, input logic [15:0] im);
        logic [FW-1:0] f;
        for (int b = 0; b < NPT; b++) f[b*BW +: BW] = {re, im};
        return f;
    endfunction

    function automatic logic [FW-1:0] set_bin(input logic [FW-1:0] f, input int b,
                                              input logic [15:0] re, input logic [15:0] im);
        logic [FW-1:0] g = f;
        g[b*BW +: BW] = {re, im};
        return g;
    endfunction

    task automatic send(input logic [FW-1:0] f, input logic [BW-1:0] thr);
        fft_d     = f;
        threshold = thr;
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int already);
        int n = already;
        while (done0 !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, done0, 1'b1);
        chk({nm, "_latency"}, n, NPT + 2);
    endtask

    initial begin
        logic [FW-1:0] f;

        rst = 1'b0;
        tick(); tick();
        chk("rst_ready", if0.fft_ready, 1'b1);
        chk("rst_done", done0, 1'b0);
        chk("rst_freq", freq0, 0);
        chk("rst_mag", mag0, 0);
        chk("rst_ovf", ovf0, 1'b0);
        rst = 1'b1;
        chk_en = 1;
        tick();

        // single peak
        f = set_bin(fill(16'h0010, 16'h0000), 5, 16'h0300, 16'h0000);
        send(f, 32'h0);
        wait_done("t1", 0);
        chk("t1_freq", freq0, 5);
        chk("t1_mag", mag0, 32'h0009_0000);
        chk("t1_np", np0, 1'b0);
        chk("t1_model_mag", e_mag[0], 32'h0009_0000);
        tick(); tick();

        // tie with a negative component: lowest index wins
        f = set_bin(set_bin(fill(16'h0, 16'h0), 3, 16'hFE00, 16'h0000), 9, 16'h0000, 16'h0200);
        send(f, 32'h0);
        wait_done("t2", 0);
        chk("t2_freq", freq0, 3);
        chk("t2_mag", mag0, 32'h0004_0000);
        chk("t2_freq_skip", freq1, 3);
        tick();

        // DC skip
        f = set_bin(set_bin(fill(16'h0, 16'h0), 0, 16'h7FFF, 16'h0000), 12, 16'h0100, 16'h0000);
        send(f, 32'h0);
        wait_done("t3", 0);
        chk("t3_freq_skip", freq1, 12);
        chk("t3_mag_skip", mag1, 32'h0001_0000);
        chk("t3_freq_dc", freq0, 0);
        chk("t3_mag_dc", mag0, 32'h3FFF_0001);
        tick(); tick(); tick();

        // threshold not met, all bins equal
        send(fill(16'h0008, 16'h0000), 32'h0000_0100);
        wait_done("t4", 0);
        chk("t4_freq", freq0, 0);
        chk("t4_mag", mag0, 32'h0000_0040);
        chk("t4_np", np0, 1'b1);
        chk("t4_freq_skip", freq1, 1);
        tick();

        // busy drop, overflow clear, accept in DONE
        fft_d     = fill(16'h0008, 16'h0000);
        threshold = 32'h0;
        fft_valid = 1'b1;
        tick();
        tick();
        chk("t5_ovf_set", ovf0, 1'b1);
        tick();
        fft_valid = 1'b0;
        clr_ovf   = 1'b1;
        tick();
        clr_ovf   = 1'b0;
        chk("t5_ovf_clr", ovf0, 1'b0);
        wait_done("t5", 3);
        chk("t5_mag", mag0, 32'h0000_0040);
        send(set_bin(fill(16'h0010, 16'h0000), 5, 16'h0300, 16'h0000), 32'h0);
        chk("t5_accept_in_done", if0.fft_ready, 1'b0);
        chk("t5_no_ovf", ovf0, 1'b0);
        wait_done("t5b", 0);
        chk("t5b_freq", freq0, 5);
        tick();

        // reset in the middle of a scan
        send(fill(16'h0020, 16'h0000), 32'h0);
        repeat (7) tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_ready", if0.fft_ready, 1'b1);
        chk("t6_rst_freq", freq0, 0);
        chk("t6_rst_mag", mag0, 0);
        chk("t6_rst_done", done0, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("t6_no_done", done0, 1'b0);
        end
        rst = 1'b1;
        tick();
        f = set_bin(fill(16'h0010, 16'h0000), 15, 16'h8000, 16'h8000);
        send(f, 32'h8000_0000);
        wait_done("t6", 0);
        chk("t6_freq", freq0, 15);
        chk("t6_mag", mag0, 32'h8000_0000);
        chk("t6_np_equal_thr", np0, 1'b0);
        tick(); tick();

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
